// File: rtl/mersenne_trial_ctrl.sv
// mersenne_trial_ctrl: tests whether q divides 2^p-1 via 2^p mod q using shared squarer/divider.
// Optional macro MERSENNE_MOD8_FILTER_EN rejects q with q mod 8 not in {1,7} before exponentiation.
`default_nettype none

module mersenne_trial_ctrl #(
  parameter int SQ_LATENCY = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic [31:0] exponent,
  input  logic [31:0] candidate,
  output logic        busy,
  output logic        done,
  output logic        is_factor,
  output logic        err,
  output logic [31:0] sq_x,
  input  logic [63:0] sq_y,
  output logic        div_start,
  output logic [63:0] div_numerator,
  output logic [31:0] div_denominator,
  input  logic        div_finished,
  input  logic [31:0] div_remainder
);

  localparam int CW = $clog2(SQ_LATENCY + 1);
  localparam logic [CW-1:0] LAT_LAST = CW'(SQ_LATENCY - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_SCAN, S_SQUARE, S_DIV_START,
    S_DIV_WAIT, S_DOUBLE, S_NEXT, S_DONE
  } state_t;

  state_t         state_q;
  logic [31:0]    p_q, q_q, r_q, sq_x_q;
  logic [4:0]     idx_q;
  logic [CW-1:0]  lat_q;
  logic [63:0]    num_q;
  logic           busy_q, done_q, is_factor_q, err_q, div_start_q;
  logic [32:0]    dbl_t;
  logic [31:0]    dbl_d;

  // r < q, so one conditional subtract keeps 2r reduced mod q.
  assign dbl_t = {r_q, 1'b0};
  assign dbl_d = (dbl_t >= {1'b0, q_q}) ? 32'(dbl_t - {1'b0, q_q}) : dbl_t[31:0];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      p_q         <= '0;
      q_q         <= '0;
      r_q         <= 32'd1;
      idx_q       <= '0;
      lat_q       <= '0;
      sq_x_q      <= '0;
      num_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      is_factor_q <= 1'b0;
      err_q       <= 1'b0;
      div_start_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      div_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            p_q         <= exponent;
            q_q         <= candidate;
            is_factor_q <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (q_q < 32'd2 || p_q == 32'd0) begin
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end
`ifdef MERSENNE_MOD8_FILTER_EN
          else if (q_q[2:0] != 3'd1 && q_q[2:0] != 3'd7) begin
            r_q     <= 32'd0;  // forces is_factor low in DONE
            state_q <= S_DONE;
          end
`endif
          else begin
            r_q     <= 32'd1;
            idx_q   <= 5'd31;
            state_q <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (p_q[idx_q]) state_q <= S_DOUBLE;
          else            idx_q   <= idx_q - 5'd1;
        end
        S_SQUARE: begin
          if (lat_q == LAT_LAST) begin
            num_q       <= sq_y;
            div_start_q <= 1'b1;
            state_q     <= S_DIV_START;
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        S_DIV_START: state_q <= S_DIV_WAIT;
        S_DIV_WAIT: begin
          if (div_finished) begin
            r_q     <= div_remainder;
            state_q <= p_q[idx_q] ? S_DOUBLE : S_NEXT;
          end
        end
        S_DOUBLE: begin
          r_q     <= dbl_d;
          state_q <= S_NEXT;
        end
        S_NEXT: begin
          if (idx_q == 5'd0) begin
            state_q <= S_DONE;
          end else begin
            idx_q   <= idx_q - 5'd1;
            sq_x_q  <= r_q;
            lat_q   <= '0;
            state_q <= S_SQUARE;
          end
        end
        S_DONE: begin
          is_factor_q <= (r_q == 32'd1) && !err_q;
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign is_factor       = is_factor_q;
  assign err             = err_q;
  assign sq_x            = sq_x_q;
  assign div_start       = div_start_q;
  assign div_numerator   = num_q;
  assign div_denominator = q_q;

endmodule

`default_nettype wire

// File: tb/tb_mersenne_trial_ctrl.sv
// tb_mersenne_trial_ctrl: directed checks of two controller instances (SQ_LATENCY 1 and 3).
`default_nettype none

module tb_mersenne_trial_ctrl;
  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        start1 = 1'b0, start3 = 1'b0, stray1 = 1'b0;
  logic [31:0] exponent = '0, candidate = '0;

  logic        busy1, done1, isf1, err1, ds1, fin1, fin1_r;
  logic [31:0] sqx1, den1, rem1;
  logic [63:0] sqy1, num1;
  logic        busy3, done3, isf3, err3, ds3, fin3;
  logic [31:0] sqx3, den3, rem3;
  logic [63:0] sqy3, sq3_s1, num3;

  int n_cmp = 0, n_bad = 0;
  int ds_cnt1 = 0, ds_cnt3 = 0, den_bad1 = 0, den_bad3 = 0;
  int stab1 = 0, stab3 = 0, stab_bad1 = 0, stab_bad3 = 0, dcnt3 = 0, dly3 = 1;
  logic [31:0] prev_x1 = '0, prev_x3 = '0, exp_q1 = '0, exp_q3 = '0;

  always #5 sys_clk = ~sys_clk;

  mersenne_trial_ctrl #(.SQ_LATENCY(1)) dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start1), .exponent(exponent),
    .candidate(candidate), .busy(busy1), .done(done1), .is_factor(isf1), .err(err1),
    .sq_x(sqx1), .sq_y(sqy1), .div_start(ds1), .div_numerator(num1),
    .div_denominator(den1), .div_finished(fin1), .div_remainder(rem1));

  mersenne_trial_ctrl #(.SQ_LATENCY(3)) dut3 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start3), .exponent(exponent),
    .candidate(candidate), .busy(busy3), .done(done3), .is_factor(isf3), .err(err3),
    .sq_x(sqx3), .sq_y(sqy3), .div_start(ds3), .div_numerator(num3),
    .div_denominator(den3), .div_finished(fin3), .div_remainder(rem3));

  // Squarers: combinational for latency 1, two register stages for latency 3.
  assign sqy1 = {32'd0, sqx1} * {32'd0, sqx1};
  always @(posedge sys_clk) begin
    sq3_s1 <= {32'd0, sqx3} * {32'd0, sqx3};
    sqy3   <= sq3_s1;
  end

  // Divider models: fixed one-cycle finish, and a random 1..4 cycle finish.
  assign fin1 = fin1_r | stray1;
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      fin1_r <= 1'b0; rem1 <= '0;
    end else begin
      fin1_r <= ds1;
      if (ds1) rem1 <= 32'(num1 % {32'd0, den1});
    end
  end

  always @(posedge sys_clk) dly3 <= int'($urandom_range(1, 4));

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      fin3 <= 1'b0; rem3 <= '0; dcnt3 <= 0;
    end else begin
      fin3 <= 1'b0;
      if (ds3) begin
        rem3 <= 32'(num3 % {32'd0, den3});
        if (dly3 == 1) fin3 <= 1'b1;
        else           dcnt3 <= dly3 - 1;
      end else if (dcnt3 != 0) begin
        dcnt3 <= dcnt3 - 1;
        if (dcnt3 == 1) fin3 <= 1'b1;
      end
    end
  end

  // Monitors: div_start count, denominator stability, sq_x hold time before each launch.
  always @(negedge sys_clk) begin
    if (ds1) ds_cnt1 <= ds_cnt1 + 1;
    if (ds3) ds_cnt3 <= ds_cnt3 + 1;
    if (busy1 && den1 != exp_q1) den_bad1 <= den_bad1 + 1;
    if (busy3 && den3 != exp_q3) den_bad3 <= den_bad3 + 1;
    stab1 <= (sqx1 != prev_x1) ? 1 : stab1 + 1;
    stab3 <= (sqx3 != prev_x3) ? 1 : stab3 + 1;
    prev_x1 <= sqx1;
    prev_x3 <= sqx3;
    if (ds1 && (sqx1 != prev_x1 || stab1 < 1)) stab_bad1 <= stab_bad1 + 1;
    if (ds3 && (sqx3 != prev_x3 || stab3 < 3)) stab_bad3 <= stab_bad3 + 1;
  end

  task automatic do_run(input bit sel, input logic [31:0] p, input logic [31:0] q,
                        output logic f, output logic e, output logic b_acc, output logic b_done,
                        output int cyc, output int divs, output int dbad, output int sbad);
    int ds0, db0, sb0;
    @(negedge sys_clk);
    exponent = p; candidate = q;
    if (sel) begin start3 = 1'b1; exp_q3 = q; end
    else     begin start1 = 1'b1; exp_q1 = q; end
    ds0 = sel ? ds_cnt3 : ds_cnt1;
    db0 = sel ? den_bad3 : den_bad1;
    sb0 = sel ? stab_bad3 : stab_bad1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    start1 = 1'b0; start3 = 1'b0;
    b_acc = sel ? busy3 : busy1;
    cyc = 0;
    while (cyc >= 0) begin
      @(posedge sys_clk);
      cyc++;
      @(negedge sys_clk);
      if (sel ? done3 : done1) break;
      if (cyc > 3000) cyc = -1;
    end
    f = sel ? isf3 : isf1;
    e = sel ? err3 : err1;
    b_done = sel ? busy3 : busy1;
    divs = (sel ? ds_cnt3 : ds_cnt1) - ds0;
    dbad = (sel ? den_bad3 : den_bad1) - db0;
    sbad = (sel ? stab_bad3 : stab_bad1) - sb0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge sys_clk);
    n_cmp++;
    if ({busy1, done1, isf1, err1, ds1, busy3, done3, isf3, err3, ds3} !== 10'd0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 0", {busy1, done1, isf1, err1, ds1, busy3, done3, isf3, err3, ds3});
    end
    n_cmp++;
    if ({sqx1, num1, den1, sqx3, num3, den3} !== 256'd0) begin
      n_bad++;
      $display("FAIL reset_operands: got sq_x=%h num=%h den=%h want 0", sqx1, num1, den1);
    end
    sys_rst_n = 1'b1;
  endtask

  task automatic test_factor();
    logic [31:0] tp [4] = '{32'd11, 32'd11, 32'd23, 32'd11};
    logic [31:0] tq [4] = '{32'd23, 32'd89, 32'd47, 32'd7};
    logic        tf [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    int          tc [4] = '{47, 47, 51, 47};
    int          td [4] = '{3, 3, 4, 3};
    logic f, e, ba, bd;
    int cyc, divs, dbad, sbad;
    for (int i = 0; i < 4; i++) begin
      do_run(1'b0, tp[i], tq[i], f, e, ba, bd, cyc, divs, dbad, sbad);
      n_cmp++;
      if ({f, e} !== {tf[i], 1'b0}) begin
        n_bad++; $display("FAIL factor p=%0d q=%0d: got is_factor=%b err=%b want %b/0", tp[i], tq[i], f, e, tf[i]);
      end
      n_cmp++;
      if (cyc !== tc[i]) begin
        n_bad++; $display("FAIL latency p=%0d q=%0d: got %0d cycles want %0d", tp[i], tq[i], cyc, tc[i]);
      end
      n_cmp++;
      if (divs !== td[i]) begin
        n_bad++; $display("FAIL div_starts p=%0d q=%0d: got %0d want %0d", tp[i], tq[i], divs, td[i]);
      end
      n_cmp++;
      if ({ba, bd, dbad, sbad} !== {1'b1, 1'b0, 32'd0, 32'd0}) begin
        n_bad++; $display("FAIL busy_den_hold p=%0d q=%0d: got busy %b->%b den_bad=%0d hold_bad=%0d want 1->0 0 0", tp[i], tq[i], ba, bd, dbad, sbad);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] tp [3] = '{32'd11, 32'd11, 32'd0};
    logic [31:0] tq [3] = '{32'd0, 32'd1, 32'd23};
    logic f, e, ba, bd;
    int cyc, divs, dbad, sbad;
    for (int i = 0; i < 3; i++) begin
      do_run(1'b0, tp[i], tq[i], f, e, ba, bd, cyc, divs, dbad, sbad);
      n_cmp++;
      if ({f, e, bd} !== 3'b010 || cyc !== 2 || divs !== 0) begin
        n_bad++; $display("FAIL error p=%0d q=%0d: got f=%b e=%b busy=%b cyc=%0d divs=%0d want 0 1 0 2 0", tp[i], tq[i], f, e, bd, cyc, divs);
      end
    end
    repeat (3) @(negedge sys_clk);
    n_cmp++;
    if ({err1, isf1, done1} !== 3'b100) begin
      n_bad++; $display("FAIL err_hold: got err=%b is_factor=%b done=%b want 1 0 0", err1, isf1, done1);
    end
  endtask

  task automatic test_mod8();
    logic f, e, ba, bd;
    int cyc, divs, dbad, sbad, ecyc, edivs;
`ifdef MERSENNE_MOD8_FILTER_EN
    ecyc = 2; edivs = 0;
`else
    ecyc = 47; edivs = 3;
`endif
    do_run(1'b0, 32'd11, 32'd13, f, e, ba, bd, cyc, divs, dbad, sbad);
    n_cmp++;
    if ({f, e} !== 2'b00 || cyc !== ecyc || divs !== edivs) begin
      n_bad++; $display("FAIL mod8 q=13: got f=%b e=%b cyc=%0d divs=%0d want 0 0 %0d %0d", f, e, cyc, divs, ecyc, edivs);
    end
  endtask

  task automatic test_busy_start();
    int cyc;
    @(negedge sys_clk);
    exponent = 32'd11; candidate = 32'd23; exp_q1 = 32'd23; start1 = 1'b1;
    @(negedge sys_clk);
    start1 = 1'b0;
    repeat (10) @(negedge sys_clk);
    exponent = 32'd11; candidate = 32'd13; start1 = 1'b1; stray1 = 1'b1;
    @(negedge sys_clk);
    start1 = 1'b0; stray1 = 1'b0; exponent = '0; candidate = '0;
    cyc = 0;
    while (!done1 && cyc < 3000) begin
      @(negedge sys_clk);
      cyc++;
    end
    n_cmp++;
    if ({done1, isf1, err1} !== 3'b110) begin
      n_bad++; $display("FAIL busy_start_ignored: got done=%b is_factor=%b err=%b want 1 1 0", done1, isf1, err1);
    end
    @(negedge sys_clk);
    n_cmp++;
    if (busy1 !== 1'b0) begin
      n_bad++; $display("FAIL busy_start_rearm: got busy=%b want 0", busy1);
    end
  endtask

  task automatic test_reset_mid();
    logic f, e, ba, bd;
    int cyc, divs, dbad, sbad, n;
    @(negedge sys_clk);
    exponent = 32'd11; candidate = 32'd23; exp_q1 = 32'd23; start1 = 1'b1;
    @(negedge sys_clk);
    start1 = 1'b0;
    n = 0;
    while (!ds1 && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy1, done1, isf1, err1, ds1} !== 5'd0 || {sqx1, num1, den1} !== 128'd0 || n >= 200) begin
      n_bad++; $display("FAIL reset_mid: got flags=%b sq_x=%h num=%h den=%h waited=%0d want all 0", {busy1, done1, isf1, err1, ds1}, sqx1, num1, den1, n);
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    do_run(1'b0, 32'd11, 32'd23, f, e, ba, bd, cyc, divs, dbad, sbad);
    n_cmp++;
    if ({f, e} !== 2'b10 || cyc !== 47) begin
      n_bad++; $display("FAIL after_reset_run: got f=%b e=%b cyc=%0d want 1 0 47", f, e, cyc);
    end
  endtask

  task automatic test_latency3();
    logic [31:0] tp [4] = '{32'd11, 32'd11, 32'd23, 32'd11};
    logic [31:0] tq [4] = '{32'd23, 32'd89, 32'd47, 32'd7};
    logic        tf [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    int          tmin [4] = '{53, 53, 59, 53};
    int          td [4] = '{3, 3, 4, 3};
    logic f, e, ba, bd;
    int cyc, divs, dbad, sbad;
    for (int i = 0; i < 4; i++) begin
      do_run(1'b1, tp[i], tq[i], f, e, ba, bd, cyc, divs, dbad, sbad);
      n_cmp++;
      if ({f, e} !== {tf[i], 1'b0} || divs !== td[i]) begin
        n_bad++; $display("FAIL lat3 p=%0d q=%0d: got f=%b e=%b divs=%0d want %b 0 %0d", tp[i], tq[i], f, e, divs, tf[i], td[i]);
      end
      n_cmp++;
      if (sbad !== 0 || dbad !== 0 || cyc < tmin[i] || cyc > tmin[i] + 3 * td[i]) begin
        n_bad++; $display("FAIL lat3_timing p=%0d q=%0d: got cyc=%0d hold_bad=%0d den_bad=%0d want %0d..%0d 0 0", tp[i], tq[i], cyc, sbad, dbad, tmin[i], tmin[i] + 3 * td[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_factor();
    test_errors();
    test_mod8();
    test_busy_start();
    test_reset_mid();
    test_latency3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
